// File: rtl/board_printer.sv
// Serializes an N x N tile-exponent board plus score into an ASCII frame,
// one byte per valid/ready handshake, with a shared sequential BCD converter.
module board_printer #(
  parameter int N            = 4,
  parameter int TILE_W       = 4,
  parameter int CELL_CHARS   = 6,
  parameter int SCORE_W      = 21,
  parameter int SCORE_DIGITS = 7,
  parameter int CLEAR_SCREEN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*N*TILE_W-1:0]   board,
  input  logic [SCORE_W-1:0]      score,
  output logic [7:0]              char_out,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    busy,
  output logic                    done
);
  localparam int TV   = (1 << TILE_W) - 1;
  localparam int VW   = (TV > SCORE_W) ? TV : SCORE_W;
  localparam int D    = (VW * 302 + 999) / 1000 + 1;
  localparam int MF0  = (CELL_CHARS > SCORE_DIGITS) ? CELL_CHARS : SCORE_DIGITS;
  localparam int MAXF = (MF0 > 7) ? MF0 : 7;
  localparam int IW   = $clog2(MAXF);
  localparam int CW   = $clog2(VW + 1);
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [55:0] LABEL = "Score: ";

  typedef enum logic [3:0] {IDLE, SNAP, CLR, CONV, CELL, EOL, LBL, SCONV, SDIG, FEOL, DONE} state_t;

  state_t                state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [RW-1:0]         row, row_n, col, col_n;
  logic [CW-1:0]         cnt;
  logic [N*N*TILE_W-1:0] board_q, src;
  logic [SCORE_W-1:0]    score_q;
  logic [VW-1:0]         bin, ld_val;
  logic [D*4-1:0]        bcd;
  logic [TILE_W-1:0]     cur_e, ld_e;
  logic                  ld, ld_score, xfer;
  logic [7:0]            ch;
  int                    ndig, ii, p;

  function automatic logic [D*4+VW-1:0] dd_step(input logic [D*4-1:0] b, input logic [VW-1:0] v);
    logic [D*4-1:0] t;
    t = b;
    for (int i = 0; i < D; i++)
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    return {t, v} << 1;
  endfunction

  assign xfer  = char_valid & char_ready;
  assign cur_e = board_q[(int'(row) * N + int'(col)) * TILE_W +: TILE_W];
  // The first field is loaded while leaving SNAP, before board_q has settled.
  assign src   = (state == SNAP) ? board : board_q;
  assign ld_e  = src[(int'(row_n) * N + int'(col_n)) * TILE_W +: TILE_W];

  always_comb begin
    ld_val = '0;
    if (ld_score)        ld_val = VW'(score_q);
    else if (ld_e != '0) ld_val = VW'(1) << ld_e;
  end

  always_comb begin
    ndig = 1;
    for (int i = 0; i < D; i++)
      if (bcd[i*4 +: 4] != 4'd0) ndig = i + 1;
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    row_n    = row;
    col_n    = col;
    ld       = 1'b0;
    ld_score = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = SNAP; idx_n = '0; row_n = '0; col_n = '0;
      end
      SNAP: if (CLEAR_SCREEN != 0) state_n = CLR;
            else begin state_n = CONV; ld = 1'b1; end
      CLR: if (xfer) begin
        if (idx == IW'(6)) begin idx_n = '0; state_n = CONV; ld = 1'b1; end
        else idx_n = idx + 1'b1;
      end
      CONV:  if (cnt == CW'(VW - 1)) state_n = CELL;
      CELL: if (xfer) begin
        if (idx == IW'(CELL_CHARS - 1)) begin
          idx_n = '0;
          if (col == RW'(N - 1)) begin col_n = '0; state_n = EOL; end
          else begin col_n = col + 1'b1; state_n = CONV; ld = 1'b1; end
        end else idx_n = idx + 1'b1;
      end
      EOL: if (xfer) begin
        if (idx == IW'(1)) begin
          idx_n = '0;
          if (row == RW'(N - 1)) state_n = LBL;
          else begin row_n = row + 1'b1; state_n = CONV; ld = 1'b1; end
        end else idx_n = idx + 1'b1;
      end
      LBL: if (xfer) begin
        if (idx == IW'(6)) begin idx_n = '0; state_n = SCONV; ld = 1'b1; ld_score = 1'b1; end
        else idx_n = idx + 1'b1;
      end
      SCONV: if (cnt == CW'(VW - 1)) state_n = SDIG;
      SDIG: if (xfer) begin
        if (idx == IW'(SCORE_DIGITS - 1)) begin idx_n = '0; state_n = FEOL; end
        else idx_n = idx + 1'b1;
      end
      FEOL: if (xfer) begin
        if (idx == IW'(1)) begin idx_n = '0; state_n = DONE; end
        else idx_n = idx + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output byte is a pure function of registered state, so it holds through stalls.
  always_comb begin
    ch = 8'h00;
    ii = int'(idx);
    p  = 0;
    case (state)
      CLR: case (ii)
        0, 4:    ch = 8'h1B;
        1, 5:    ch = 8'h5B;
        2:       ch = 8'h32;
        3:       ch = 8'h4A;
        default: ch = 8'h48;
      endcase
      CELL: begin
        p = CELL_CHARS - 1 - ii;
        if (cur_e == '0)                ch = (ii == CELL_CHARS - 1) ? 8'h2E : 8'h20;
        else if (ndig > CELL_CHARS - 1) ch = 8'h23;
        else if (p < ndig)              ch = {4'h3, 4'(bcd >> (4 * p))};
        else                            ch = 8'h20;
      end
      EOL, FEOL: ch = (ii == 0) ? 8'h0D : 8'h0A;
      LBL:       ch = LABEL[(6 - ii) * 8 +: 8];
      SDIG: begin
        p = SCORE_DIGITS - 1 - ii;
        if (ndig > SCORE_DIGITS) ch = 8'h23;
        else if (p < ndig)       ch = {4'h3, 4'(bcd >> (4 * p))};
        else                     ch = 8'h20;
      end
      default: ch = 8'h00;
    endcase
  end

  assign char_out   = ch;
  assign char_valid = (state == CLR) || (state == CELL) || (state == EOL) ||
                      (state == LBL) || (state == SDIG) || (state == FEOL);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      cnt     <= '0;
      board_q <= '0;
      score_q <= '0;
      bin     <= '0;
      bcd     <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      row   <= row_n;
      col   <= col_n;
      if (state == SNAP) begin
        board_q <= board;
        score_q <= score;
      end
      if (ld) begin
        bin <= ld_val;
        bcd <= '0;
        cnt <= '0;
      end else if (state == CONV || state == SCONV) begin
        {bcd, bin} <= dd_step(bcd, bin);
        cnt        <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_board_printer.sv
// Directed bench for board_printer: default 4x4 instance plus a small 2x2
// instance with narrow cells/score field for overflow formatting.
module tb_board_printer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [63:0] board_a;
  logic [15:0] board_b;
  logic [20:0] score_a, score_b;
  logic [7:0]  a_char, b_char;
  logic        a_valid, a_ready, a_busy, a_done;
  logic        b_valid, b_ready, b_busy, b_done;

  board_printer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .board(board_a), .score(score_a),
    .char_out(a_char), .char_valid(a_valid), .char_ready(a_ready),
    .busy(a_busy), .done(a_done));

  board_printer #(.N(2), .CELL_CHARS(3), .SCORE_DIGITS(3), .CLEAR_SCREEN(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .board(board_b), .score(score_b),
    .char_out(b_char), .char_valid(b_valid), .char_ready(b_ready),
    .busy(b_busy), .done(b_done));

  typedef struct {
    bit          sel;
    logic [63:0] bd;
    logic [20:0] sc;
    int          pos;
    string       exp;
  } vec_t;

  vec_t        vecs[$];
  byte         qa[$], qb[$], saved[$];
  int          checks = 0, errors = 0;
  int          a_dn = 0, b_dn = 0;
  logic        a_st = 1'b0, rst_prev = 1'b0, rand_rdy = 1'b0;
  logic [7:0]  a_pc = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // One clock: sample at negedge, return 1ns after the posedge for driving.
  task automatic tick();
    @(negedge clk);
    if (a_valid && a_ready) qa.push_back(a_char);
    if (b_valid && b_ready) qb.push_back(b_char);
    if (a_done) begin a_dn++; chk("busy_low_at_done_a", int'(a_busy), 0); end
    if (b_done) begin b_dn++; chk("busy_low_at_done_b", int'(b_busy), 0); end
    if (a_st && rst_prev) begin
      chk("stall_valid_held", int'(a_valid), 1);
      chk("stall_char_held", int'(a_char), int'(a_pc));
    end
    a_st     = a_valid && !a_ready;
    a_pc     = a_char;
    rst_prev = rst;
    @(posedge clk);
    #1;
    if (rand_rdy) a_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic add_vec(input bit sel, input logic [63:0] bd, input logic [20:0] sc,
                         input int pos, input string exp);
    vec_t v;
    v.sel = sel; v.bd = bd; v.sc = sc; v.pos = pos; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic run_frame(input bit sel, input logic [63:0] bd, input logic [20:0] sc,
                           input bit tchk, input bit midstart);
    int cyc;
    qa.delete(); qb.delete(); a_dn = 0; b_dn = 0;
    if (sel) begin board_b = bd[15:0]; score_b = sc; start_b = 1'b1; end
    else     begin board_a = bd;       score_a = sc; start_a = 1'b1; end
    tick();
    if (tchk) begin
      chk("busy_after_start", int'(a_busy), 1);
      chk("snap_no_valid", int'(a_valid), 0);
    end
    start_a = 1'b0; start_b = 1'b0;
    tick();
    if (tchk) begin
      chk("first_byte_valid", int'(a_valid), 1);
      chk("first_byte_esc", int'(a_char), 8'h1B);
    end
    cyc = 0;
    while ((sel ? b_dn : a_dn) == 0 && cyc < 5000) begin
      if (midstart && cyc == 60) start_a = 1'b1;
      if (midstart && cyc == 62) start_a = 1'b0;
      tick();
      cyc++;
    end
    if (cyc >= 5000) chk("frame_timeout", cyc, 0);
    repeat (4) tick();
    chk(sel ? "frame_len_b" : "frame_len_a", sel ? qb.size() : qa.size(), sel ? 28 : 127);
    chk("done_pulses", sel ? b_dn : a_dn, 1);
  endtask

  initial begin
    int n, bad, g;
    rst = 1'b0; start_a = 1'b1; start_b = 1'b0;
    board_a = '0; board_b = '0; score_a = '0; score_b = '0;
    a_ready = 1'b1; b_ready = 1'b1;

    add_vec(0, 64'h0, 21'd0, 0,   "\033[2J\033[H");
    add_vec(0, 64'h0, 21'd0, 7,   "     .     .     .     .\015\012");
    add_vec(0, 64'h0, 21'd0, 111, "Score:       0\015\012");
    add_vec(0, 64'h1000_0000_0000_000B, 21'd20512, 7,   "  2048     .     .     .\015\012");
    add_vec(0, 64'h1000_0000_0000_000B, 21'd20512, 85,  "     .     .     .     2\015\012");
    add_vec(0, 64'h1000_0000_0000_000B, 21'd20512, 111, "Score:   20512\015\012");
    add_vec(0, 64'h0000_0000_FE74_0000, 21'd2097151, 33,  "    16   128 16384 32768\015\012");
    add_vec(0, 64'h0000_0000_FE74_0000, 21'd2097151, 111, "Score: 2097151\015\012");
    add_vec(1, 64'h306A, 21'd1000, 0,  "### 64\015\012  .  8\015\012Score: ###\015\012");
    add_vec(1, 64'h306A, 21'd999,  16, "Score: 999\015\012");
    add_vec(1, 64'h0,    21'd0,    0,  "  .  .\015\012  .  .\015\012Score:   0\015\012");

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", int'(a_valid), 0);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_done", int'(a_done), 0);
    end
    chk("rst_char", int'(a_char), 0);
    rst = 1'b1; start_a = 1'b0;
    repeat (20) tick();
    chk("idle_no_bytes", qa.size(), 0);
    chk("idle_busy", int'(a_busy), 0);

    // Table-driven frames
    for (int v = 0; v < vecs.size(); v++) begin
      run_frame(vecs[v].sel, vecs[v].bd, vecs[v].sc, v == 0, 1'b0);
      bad = -1; g = -1;
      for (int i = 0; i < vecs[v].exp.len(); i++) begin
        n = vecs[v].pos + i;
        g = vecs[v].sel ? ((n < qb.size()) ? int'(qb[n]) & 255 : -1)
                        : ((n < qa.size()) ? int'(qa[n]) & 255 : -1);
        if (g != (int'(vecs[v].exp[i]) & 255)) begin bad = i; break; end
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL vec%0d byte %0d: got %0d, required %0d", v, vecs[v].pos + bad, g,
                 int'(vecs[v].exp[bad]) & 255);
      end
    end

    // Stall-free reference, then the same frame under random backpressure
    run_frame(0, 64'h0000_0000_FE74_0000, 21'd2097151, 1'b0, 1'b0);
    saved = qa;
    rand_rdy = 1'b1;
    run_frame(0, 64'h0000_0000_FE74_0000, 21'd2097151, 1'b0, 1'b0);
    rand_rdy = 1'b0; a_ready = 1'b1;
    bad = -1;
    for (int i = 0; i < saved.size() && i < qa.size(); i++)
      if (saved[i] != qa[i]) begin bad = i; break; end
    chk("stall_stream_first_diff", bad, -1);

    // start pulsed mid-frame is ignored
    run_frame(0, 64'h1000_0000_0000_000B, 21'd20512, 1'b0, 1'b1);

    // Reset mid-frame aborts without done
    qa.delete(); a_dn = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (60) tick();
    rst = 1'b0; tick();
    chk("abort_valid", int'(a_valid), 0);
    chk("abort_busy", int'(a_busy), 0);
    n = qa.size();
    rst = 1'b1;
    repeat (300) tick();
    chk("abort_no_bytes", qa.size(), n);
    chk("abort_no_done", a_dn, 0);
    run_frame(0, 64'h0, 21'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
